mdu_sequencer: RTL and testbench

Multi-cycle sequencer for the RV32M multiply/divide operations, decoded as R-type with Funct7 bit 0 set. The combinational ALU leaves these encodings unsupported. The block sits beside the ALU in the execute stage and accepts one operation per start pulse. It iterates a shared 32-bit add/subtract datapath for 32 cycles while holding the PC stalled, then returns a 32-bit result with a one-cycle done pulse.

---
 rtl/mdu_sequencer.sv | 157 +++++++++++++++
 tb/tb_mdu_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Purpose: RV32M multiply/divide sequencer sharing one 32-bit add/sub datapath; optional divider under MDU_DIV_EN.
// Latency: 34 cycles from Start to Done (1 cycle for divide-by-zero, signed overflow, or divide ops without MDU_DIV_EN).
// Backpressure: Stall_PC holds the PC while busy; Start outside IDLE is ignored; Flush aborts without Done.
module mdu_sequencer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Rs1,
  input  logic [31:0] Rs2,
  input  logic        Flush,
  output logic        Busy,
  output logic        Stall_PC,
  output logic        Done,
  output logic [31:0] Result
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t      state, state_n;
  logic [2:0]  op;
  logic [31:0] opnd;      // multiplicand magnitude (mul) or divisor magnitude (div)
  logic [63:0] acc;       // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [4:0]  count;
  logic        neg_res;   // product / quotient must be negated
  logic [31:0] result;

  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        special;
  logic [31:0] special_res;
  logic [63:0] acc_step;
  logic [63:0] prod;
  logic [31:0] mul_res, fix_res;
  logic        accept;

  assign accept = (state == IDLE) && Start && !Flush;

  // Operand decode at issue: signedness, magnitudes and the one-cycle special cases
  always_comb begin
    a_signed = (Funct3 == 3'b001) || (Funct3 == 3'b010) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    b_signed = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    a_neg    = a_signed && Rs1[31];
    b_neg    = b_signed && Rs2[31];
    a_mag    = a_neg ? (~Rs1 + 32'd1) : Rs1;
    b_mag    = b_neg ? (~Rs2 + 32'd1) : Rs2;
    special     = 1'b0;
    special_res = 32'h0;
`ifdef MDU_DIV_EN
    if (Funct3[2] && (Rs2 == 32'h0)) begin
      special     = 1'b1;
      special_res = Funct3[1] ? Rs1 : 32'hFFFF_FFFF;
    end else if (Funct3[2] && !Funct3[0] && (Rs1 == 32'h8000_0000) && (Rs2 == 32'hFFFF_FFFF)) begin
      special     = 1'b1;
      special_res = Funct3[1] ? 32'h0 : 32'h8000_0000;
    end
`else
    special = Funct3[2];
`endif
  end

`ifdef MDU_DIV_EN
  logic        neg_rem;   // remainder takes the dividend's sign
  logic [32:0] add_a, add_b;
  logic [33:0] sum;
  logic [31:0] quo, rem;

  // Shared adder: add for shift-add multiply, subtract for restoring divide
  always_comb begin
    add_a = op[2] ? acc[63:31] : {1'b0, acc[63:32]};
    add_b = {1'b0, opnd};
    sum   = {1'b0, add_a} + {1'b0, (op[2] ? ~add_b : add_b)} + {33'b0, op[2]};
    if (op[2])
      acc_step = sum[33] ? {sum[31:0], acc[30:0], 1'b1} : {acc[62:0], 1'b0};
    else
      acc_step = acc[0] ? {sum[32:0], acc[31:1]} : {1'b0, acc[63:1]};
  end
`else
  logic [32:0] sum;

  // Adder used only for shift-add multiply
  always_comb begin
    sum      = {1'b0, acc[63:32]} + {1'b0, opnd};
    acc_step = acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]};
  end
`endif

  // Sign correction and word selection applied in FIXUP
  always_comb begin
    prod    = neg_res ? (~acc + 64'd1) : acc;
    mul_res = (op[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
`ifdef MDU_DIV_EN
    quo     = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem     = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
    fix_res = op[2] ? (op[1] ? rem : quo) : mul_res;
`else
    fix_res = mul_res;
`endif
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; Flush forces IDLE from any state
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = special ? DONE : CALC;
      CALC:    if (count == 5'd0) state_n = FIXUP;
      FIXUP:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (Flush) state_n = IDLE;
  end

  // Datapath registers: load at issue, iterate in CALC, capture result on entry to DONE
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op      <= 3'b0;
      opnd    <= 32'h0;
      acc     <= 64'h0;
      count   <= 5'd0;
      neg_res <= 1'b0;
`ifdef MDU_DIV_EN
      neg_rem <= 1'b0;
`endif
      result  <= 32'h0;
    end else if (!Flush) begin
      if (accept) begin
        op      <= Funct3;
        opnd    <= Funct3[2] ? b_mag : a_mag;
        acc     <= {32'h0, (Funct3[2] ? a_mag : b_mag)};
        count   <= 5'd31;
        neg_res <= a_neg ^ b_neg;
`ifdef MDU_DIV_EN
        neg_rem <= a_neg;
`endif
        if (special) result <= special_res;
      end else if (state == CALC) begin
        acc <= acc_step;
        if (count != 5'd0) count <= count - 5'd1;
      end else if (state == FIXUP) begin
        result <= fix_res;
      end
    end
  end

  assign Busy     = (state == CALC) || (state == FIXUP);
  assign Stall_PC = Busy || (Start && (state == IDLE));
  assign Done     = (state == DONE);
  assign Result   = result;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Purpose: directed and randomised checks of mdu_sequencer results, latency, stall and abort behaviour.
// Latency: expects 34 cycles for iterated ops, 1 cycle for special cases and for divide ops when MDU_DIV_EN is undefined.
// Backpressure: single outstanding operation; expected results queued at issue and popped on Done.
module tb_mdu_sequencer;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        Start;
  logic [2:0]  Funct3;
  logic [31:0] Rs1, Rs2;
  logic        Flush;
  logic        Busy, Stall_PC, Done;
  logic [31:0] Result;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_res;

  mdu_sequencer dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Funct3(Funct3), .Rs1(Rs1), .Rs2(Rs2),
    .Flush(Flush), .Busy(Busy), .Stall_PC(Stall_PC), .Done(Done), .Result(Result)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    r = 32'h0;
    case (f3)
      3'b000: begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
      3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
      3'b010: begin p = {{32{a[31]}}, a} * {32'h0, b}; r = p[63:32]; end
      3'b011: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
      default: begin
        if (!DIV_EN) r = 32'h0;
        else if (b == 32'h0) r = f3[1] ? a : 32'hFFFF_FFFF;
        else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = f3[1] ? 32'h0 : 32'h8000_0000;
        else case (f3)
          3'b100: r = $signed(a) / $signed(b);
          3'b101: r = a / b;
          3'b110: r = $signed(a) % $signed(b);
          default: r = a % b;
        endcase
      end
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 34;
    if (!DIV_EN) return 1;
    if (b == 32'h0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Wait for Done, bounded; optionally checks Busy/Stall_PC per cycle and pokes Start at cycle 'poke'
  task automatic wait_done(input string tag, input int exp_lat, input bit watch, input int poke);
    int  lat  = 0;
    bit  seen = 1'b0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge CLK);
      Start = (c == poke);
      if (c == poke) Rs1 = 32'd9;
      if (watch && c <= 33) begin
        check({tag, "_busy"}, 32'(Busy), 32'd1);
        check({tag, "_stall"}, 32'(Stall_PC), 32'd1);
      end
      if (watch && c == 34) begin
        check({tag, "_busy_done"}, 32'(Busy), 32'd0);
        check({tag, "_stall_done"}, 32'(Stall_PC), 32'd0);
      end
      if (Done) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    Start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (seen && sb_q.size() > 0) begin
      logic [31:0] e;
      e = sb_q.pop_front();
      check({tag, "_result"}, Result, e);
      last_res = e;
    end
    @(negedge CLK);
    check({tag, "_done_pulse"}, 32'(Done), 32'd0);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_r);
    @(negedge CLK);
    Funct3 = f3; Rs1 = a; Rs2 = b; Start = 1'b1;
    sb_q.push_back(exp_r);
    #1;
    check("stall_cycle0", 32'(Stall_PC), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input int exp_lat);
    issue(f3, a, b, exp_r);
    wait_done(tag, exp_lat, 1'b0, 0);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int extra = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge CLK);
      if (Done) extra++;
    end
    check(tag, 32'(extra), 32'd0);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    int          dlat;

    RST = 1'b1; Start = 1'b0; Flush = 1'b0; Funct3 = 3'b0; Rs1 = 32'h0; Rs2 = 32'h0;
    last_res = 32'h0;
    #12;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_stall", 32'(Stall_PC), 32'd0);
    check("rst_result", Result, 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    // MUL 7x6 with per-cycle Busy/Stall_PC checks
    issue(3'b000, 32'd7, 32'd6, 32'd42);
    wait_done("mul_7x6", 34, 1'b1, 0);

    run_op("mulh_m1x2",  3'b001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("mulhu_m1x2", 3'b011, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 34);
    run_op("mulhsu",     3'b010, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 34);

    dlat = DIV_EN ? 34 : 1;
    run_op("div_m20_3",  3'b100, 32'hFFFF_FFEC, 32'd3, DIV_EN ? 32'hFFFF_FFFA : 32'h0, dlat);
    run_op("rem_m20_3",  3'b110, 32'hFFFF_FFEC, 32'd3, DIV_EN ? 32'hFFFF_FFFE : 32'h0, dlat);
    run_op("divu_by0",   3'b101, 32'd100, 32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'h0, 1);
    run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, DIV_EN ? 32'h8000_0000 : 32'h0, 1);
    run_op("mul_pre",    3'b000, 32'd11, 32'd13, 32'd143, 34);

    // Randomised operations against the reference model
    for (int i = 0; i < 8; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom_range(1, 32'hFFFF);
      if (i[0]) rb = ~rb;
      run_op("random", rf3, ra, rb, model(rf3, ra, rb), model_lat(rf3, ra, rb));
    end

    // Flush in cycle 10 of a MUL: IDLE in cycle 11, no Done, Result held
    @(negedge CLK);
    Funct3 = 3'b000; Rs1 = 32'h1234; Rs2 = 32'h10; Start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge CLK);
      Start = 1'b0;
      Flush = (c == 10);
      check("flush_no_done", 32'(Done), 32'd0);
    end
    check("flush_idle", 32'(Busy), 32'd0);
    check("flush_result_held", Result, last_res);
    run_op("mul_after_flush", 3'b000, 32'd3, 32'd5, 32'd15, 34);

    // Start while busy is ignored: one Done only, with the original operands
    issue(3'b000, 32'd7, 32'd6, 32'd42);
    wait_done("start_while_busy", 34, 1'b0, 5);
    expect_quiet("no_second_done", 40);

    // Reset in cycle 20 of a long operation
    @(negedge CLK);
    Funct3 = DIV_EN ? 3'b101 : 3'b000; Rs1 = 32'd1000; Rs2 = 32'd7; Start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      Start = 1'b0;
    end
    RST = 1'b1;
    #1;
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_result", Result, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    expect_quiet("midrst_no_done", 40);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
